// File: rtl/mc_controller.sv
// mc_controller: multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) driving datapath strobes.
// Define MDU_SEQ_EN to decode mult/div/mfhi/mflo and sequence the multi-cycle MDU via MDU_WAIT.
`timescale 1ns/1ps
module mc_controller #(
  parameter int ALUOP_W     = 5,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instr,
  input  logic               br_taken,
  output logic               pc_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               mem_write,
  output logic [1:0]         npc_sel,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic [1:0]         alu_src,
  output logic [1:0]         ext_op,
  output logic [ALUOP_W-1:0] alu_ctrl,
  output logic               mdu_start,
  output logic [1:0]         mdu_op,
  output logic               mdu_busy,
  output logic [2:0]         state
);
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_MDU_WAIT = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    K_NONE, K_J, K_JAL, K_JR, K_JALR, K_BR, K_BRAL, K_LOAD, K_STORE, K_ALU, K_MDU, K_MF
  } kind_e;

  typedef struct packed {
    kind_e      kind;
    logic       rtype;
    logic [4:0] alu;
    logic [1:0] src;
    logic [1:0] ext;
  } dec_t;

  logic [5:0] op, funct;
  logic [4:0] rt;
  logic       unused_instr;
  dec_t       dec;

  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign rt    = instr[20:16];
  assign unused_instr = ^{instr[25:21], instr[15:6]};

  // Instruction class and EXEC-phase ALU controls; depends on IR only.
  always_comb begin
    dec.kind  = K_NONE;
    dec.rtype = 1'b0;
    dec.alu   = 5'b00000;
    dec.src   = 2'd0;
    dec.ext   = 2'd0;
    case (op)
      6'h00: begin
        dec.rtype = 1'b1;
        dec.kind  = K_ALU;
        case (funct)
          6'h00: begin dec.alu = 5'b01010; dec.src = 2'd2; end
          6'h02: begin dec.alu = 5'b01000; dec.src = 2'd2; end
          6'h03: begin dec.alu = 5'b01001; dec.src = 2'd2; end
          6'h04: dec.alu = 5'b01010;
          6'h06: dec.alu = 5'b01000;
          6'h07: dec.alu = 5'b01001;
          6'h08: dec.kind = K_JR;
          6'h09: dec.kind = K_JALR;
          6'h20, 6'h21: dec.alu = 5'b00010;
          6'h22, 6'h23: dec.alu = 5'b00011;
          6'h24: dec.alu = 5'b00100;
          6'h25: dec.alu = 5'b00101;
          6'h26: dec.alu = 5'b00110;
          6'h27: dec.alu = 5'b00111;
          6'h2A: dec.alu = 5'b01100;
          6'h2B: dec.alu = 5'b01101;
`ifdef MDU_SEQ_EN
          6'h10, 6'h12: dec.kind = K_MF;
          6'h18, 6'h19, 6'h1A, 6'h1B: dec.kind = K_MDU;
`endif
          default: dec.kind = K_NONE;
        endcase
      end
      6'h01: begin
        dec.ext = 2'd3;
        case (rt)
          5'h00: begin dec.kind = K_BR;   dec.alu = 5'b00000; end
          5'h01: begin dec.kind = K_BR;   dec.alu = 5'b00001; end
          5'h11: begin dec.kind = K_BRAL; dec.alu = 5'b00001; end
          default: dec.kind = K_NONE;
        endcase
      end
      6'h02: dec.kind = K_J;
      6'h03: dec.kind = K_JAL;
      6'h04: begin dec.kind = K_BR; dec.alu = 5'b00110; dec.ext = 2'd3; end
      6'h05: begin dec.kind = K_BR; dec.alu = 5'b01011; dec.ext = 2'd3; end
      6'h06: begin dec.kind = K_BR; dec.alu = 5'b01110; dec.ext = 2'd3; end
      6'h07: begin dec.kind = K_BR; dec.alu = 5'b01111; dec.ext = 2'd3; end
      6'h08, 6'h09: begin dec.kind = K_ALU; dec.alu = 5'b00010; dec.src = 2'd1; end
      6'h0A: begin dec.kind = K_ALU; dec.alu = 5'b01100; dec.src = 2'd1; end
      6'h0B: begin dec.kind = K_ALU; dec.alu = 5'b01101; dec.src = 2'd1; end
      6'h0C: begin dec.kind = K_ALU; dec.alu = 5'b00100; dec.src = 2'd1; dec.ext = 2'd1; end
      6'h0D: begin dec.kind = K_ALU; dec.alu = 5'b00101; dec.src = 2'd1; dec.ext = 2'd1; end
      6'h0E: begin dec.kind = K_ALU; dec.alu = 5'b00110; dec.src = 2'd1; dec.ext = 2'd1; end
      6'h0F: begin dec.kind = K_ALU; dec.alu = 5'b00101; dec.src = 2'd1; dec.ext = 2'd2; end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        dec.kind = K_LOAD; dec.alu = 5'b00010; dec.src = 2'd1;
      end
      6'h28, 6'h29, 6'h2B: begin
        dec.kind = K_STORE; dec.alu = 5'b00010; dec.src = 2'd1;
      end
      default: dec.kind = K_NONE;
    endcase
    // An all-zero word would decode as sll; treat it as a bubble.
    if (instr == 32'h0) dec.kind = K_NONE;
  end

  state_e state_q, state_d;
  logic   pc_write_c, ir_write_c, reg_write_c, mem_write_c;
  logic [4:0] alu_c;

`ifdef MDU_SEQ_EN
  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mdu_start_c, mdu_busy_c;
  logic [1:0]       mdu_op_c;

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = S_FETCH;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    mem_write_c = 1'b0;
    npc_sel     = 2'd0;
    reg_dst     = 2'd0;
    mem_to_reg  = 2'd0;
    alu_src     = 2'd0;
    ext_op      = 2'd0;
    alu_c       = 5'b00000;
`ifdef MDU_SEQ_EN
    cnt_d       = cnt_q;
    mdu_start_c = 1'b0;
    mdu_busy_c  = 1'b0;
    mdu_op_c    = 2'd0;
`endif
    case (state_q)
      S_FETCH: begin
        ir_write_c = 1'b1;
        pc_write_c = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        case (dec.kind)
          K_NONE: ;
          K_J:    begin pc_write_c = 1'b1; npc_sel = 2'd2; end
          K_JAL:  begin
            pc_write_c = 1'b1; npc_sel = 2'd2;
            reg_write_c = 1'b1; reg_dst = 2'd2; mem_to_reg = 2'd2;
          end
          K_JR:   begin pc_write_c = 1'b1; npc_sel = 2'd3; end
          K_JALR: begin
            pc_write_c = 1'b1; npc_sel = 2'd3;
            reg_write_c = 1'b1; reg_dst = 2'd1; mem_to_reg = 2'd2;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        alu_c   = dec.alu;
        alu_src = dec.src;
        ext_op  = dec.ext;
        case (dec.kind)
          K_BR: begin pc_write_c = br_taken; npc_sel = 2'd1; end
          K_BRAL: begin
            pc_write_c = br_taken; npc_sel = 2'd1;
            reg_write_c = 1'b1; reg_dst = 2'd2; mem_to_reg = 2'd2;
          end
          K_LOAD, K_STORE: state_d = S_MEM;
          K_ALU, K_MF:     state_d = S_WB;
`ifdef MDU_SEQ_EN
          K_MDU: begin
            mdu_start_c = 1'b1;
            mdu_op_c    = funct[1:0];
            cnt_d       = funct[1] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
            state_d     = S_MDU_WAIT;
          end
`endif
          default: ;
        endcase
      end
      S_MEM: begin
        if (dec.kind == K_STORE) mem_write_c = 1'b1;
        else if (dec.kind == K_LOAD) state_d = S_WB;
      end
      S_WB: begin
        reg_write_c = 1'b1;
        reg_dst     = dec.rtype ? 2'd1 : 2'd0;
        if (dec.kind == K_LOAD)    mem_to_reg = 2'd1;
        else if (dec.kind == K_MF) mem_to_reg = 2'd3;
`ifdef MDU_SEQ_EN
        if (dec.kind == K_MF) mdu_op_c = {1'b0, funct[1]};
`endif
      end
`ifdef MDU_SEQ_EN
      S_MDU_WAIT: begin
        mdu_busy_c = 1'b1;
        mdu_op_c   = funct[1:0];
        if (cnt_q != '0) begin
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = S_MDU_WAIT;
        end
      end
`endif
      default: ;
    endcase
  end

  assign pc_write  = pc_write_c  & ~reset;
  assign ir_write  = ir_write_c  & ~reset;
  assign reg_write = reg_write_c & ~reset;
  assign mem_write = mem_write_c & ~reset;
  assign alu_ctrl  = ALUOP_W'(alu_c);
  assign state     = state_q;

`ifdef MDU_SEQ_EN
  assign mdu_start = mdu_start_c & ~reset;
  assign mdu_busy  = mdu_busy_c;
  assign mdu_op    = mdu_op_c;
`else
  assign mdu_start = 1'b0;
  assign mdu_busy  = 1'b0;
  assign mdu_op    = 2'd0;
`endif
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: random instruction stream checked per cycle against a table-driven
// phase model of each instruction; adapts to the MDU_SEQ_EN build option.
`timescale 1ns/1ps
module tb_mc_controller;
  localparam int ALUOP_W = 5, MULT_CYCLES = 5, DIV_CYCLES = 10;

  logic clk = 1'b0, reset = 1'b1, br_taken = 1'b0;
  logic [31:0] instr = 32'h0;
  logic pc_write, ir_write, reg_write, mem_write, mdu_start, mdu_busy;
  logic [1:0] npc_sel, reg_dst, mem_to_reg, alu_src, ext_op, mdu_op;
  logic [ALUOP_W-1:0] alu_ctrl;
  logic [2:0] state;

  mc_controller #(.ALUOP_W(ALUOP_W), .MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .instr(instr), .br_taken(br_taken),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write), .mem_write(mem_write),
    .npc_sel(npc_sel), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
    .ext_op(ext_op), .alu_ctrl(alu_ctrl), .mdu_start(mdu_start), .mdu_op(mdu_op),
    .mdu_busy(mdu_busy), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef enum int {K_J, K_JAL, K_JR, K_JALR, K_BR, K_BRAL, K_LD, K_ST, K_ALU, K_MDU, K_MF} kind_t;
  typedef struct {
    logic [5:0] op;
    logic [5:0] sub;
    kind_t      kind;
    logic [4:0] alu;
    logic [1:0] src;
    logic [1:0] ext;
  } desc_t;
  desc_t tbl[$];

  // One expected output cycle; c_* marks selects that matter in that cycle.
  typedef struct packed {
    logic [2:0] st;
    logic pcw, irw, rw, mw, ms, mb;
    logic [1:0] npc, rd, m2r, src, ext, mop;
    logic [4:0] alu;
    logic c_npc, c_rd, c_m2r, c_src, c_ext, c_alu, c_mop;
  } exp_t;
  exp_t exp_q[$];

  task automatic add(input logic [5:0] op, input logic [5:0] sub, input kind_t k,
                     input logic [4:0] alu, input logic [1:0] src, input logic [1:0] ext);
    desc_t d;
    d.op = op; d.sub = sub; d.kind = k; d.alu = alu; d.src = src; d.ext = ext;
    tbl.push_back(d);
  endtask

  task automatic init_table();
    add(6'h00, 6'h00, K_ALU, 5'b01010, 2'd2, 2'd0); add(6'h00, 6'h02, K_ALU, 5'b01000, 2'd2, 2'd0);
    add(6'h00, 6'h03, K_ALU, 5'b01001, 2'd2, 2'd0); add(6'h00, 6'h04, K_ALU, 5'b01010, 2'd0, 2'd0);
    add(6'h00, 6'h06, K_ALU, 5'b01000, 2'd0, 2'd0); add(6'h00, 6'h07, K_ALU, 5'b01001, 2'd0, 2'd0);
    add(6'h00, 6'h08, K_JR,  5'b00000, 2'd0, 2'd0); add(6'h00, 6'h09, K_JALR, 5'b00000, 2'd0, 2'd0);
    add(6'h00, 6'h10, K_MF,  5'b00000, 2'd0, 2'd0); add(6'h00, 6'h12, K_MF,  5'b00000, 2'd0, 2'd0);
    add(6'h00, 6'h18, K_MDU, 5'b00000, 2'd0, 2'd0); add(6'h00, 6'h19, K_MDU, 5'b00000, 2'd0, 2'd0);
    add(6'h00, 6'h1A, K_MDU, 5'b00000, 2'd0, 2'd0); add(6'h00, 6'h1B, K_MDU, 5'b00000, 2'd0, 2'd0);
    add(6'h00, 6'h20, K_ALU, 5'b00010, 2'd0, 2'd0); add(6'h00, 6'h21, K_ALU, 5'b00010, 2'd0, 2'd0);
    add(6'h00, 6'h22, K_ALU, 5'b00011, 2'd0, 2'd0); add(6'h00, 6'h23, K_ALU, 5'b00011, 2'd0, 2'd0);
    add(6'h00, 6'h24, K_ALU, 5'b00100, 2'd0, 2'd0); add(6'h00, 6'h25, K_ALU, 5'b00101, 2'd0, 2'd0);
    add(6'h00, 6'h26, K_ALU, 5'b00110, 2'd0, 2'd0); add(6'h00, 6'h27, K_ALU, 5'b00111, 2'd0, 2'd0);
    add(6'h00, 6'h2A, K_ALU, 5'b01100, 2'd0, 2'd0); add(6'h00, 6'h2B, K_ALU, 5'b01101, 2'd0, 2'd0);
    add(6'h01, 6'h00, K_BR,  5'b00000, 2'd0, 2'd3); add(6'h01, 6'h01, K_BR,  5'b00001, 2'd0, 2'd3);
    add(6'h01, 6'h11, K_BRAL, 5'b00001, 2'd0, 2'd3);
    add(6'h02, 6'h00, K_J,   5'b00000, 2'd0, 2'd0); add(6'h03, 6'h00, K_JAL, 5'b00000, 2'd0, 2'd0);
    add(6'h04, 6'h00, K_BR,  5'b00110, 2'd0, 2'd3); add(6'h05, 6'h00, K_BR,  5'b01011, 2'd0, 2'd3);
    add(6'h06, 6'h00, K_BR,  5'b01110, 2'd0, 2'd3); add(6'h07, 6'h00, K_BR,  5'b01111, 2'd0, 2'd3);
    add(6'h08, 6'h00, K_ALU, 5'b00010, 2'd1, 2'd0); add(6'h09, 6'h00, K_ALU, 5'b00010, 2'd1, 2'd0);
    add(6'h0A, 6'h00, K_ALU, 5'b01100, 2'd1, 2'd0); add(6'h0B, 6'h00, K_ALU, 5'b01101, 2'd1, 2'd0);
    add(6'h0C, 6'h00, K_ALU, 5'b00100, 2'd1, 2'd1); add(6'h0D, 6'h00, K_ALU, 5'b00101, 2'd1, 2'd1);
    add(6'h0E, 6'h00, K_ALU, 5'b00110, 2'd1, 2'd1); add(6'h0F, 6'h00, K_ALU, 5'b00101, 2'd1, 2'd2);
    add(6'h20, 6'h00, K_LD,  5'b00010, 2'd1, 2'd0); add(6'h21, 6'h00, K_LD,  5'b00010, 2'd1, 2'd0);
    add(6'h23, 6'h00, K_LD,  5'b00010, 2'd1, 2'd0); add(6'h24, 6'h00, K_LD,  5'b00010, 2'd1, 2'd0);
    add(6'h25, 6'h00, K_LD,  5'b00010, 2'd1, 2'd0);
    add(6'h28, 6'h00, K_ST,  5'b00010, 2'd1, 2'd0); add(6'h29, 6'h00, K_ST,  5'b00010, 2'd1, 2'd0);
    add(6'h2B, 6'h00, K_ST,  5'b00010, 2'd1, 2'd0);
  endtask

  function automatic int lookup(input logic [31:0] ins);
    if (ins == 32'h0) return -1;
    foreach (tbl[i]) begin
      if (tbl[i].op != ins[31:26]) continue;
      if (ins[31:26] == 6'h00 && tbl[i].sub != ins[5:0]) continue;
      if (ins[31:26] == 6'h01 && tbl[i].sub != {1'b0, ins[20:16]}) continue;
`ifndef MDU_SEQ_EN
      if (tbl[i].kind inside {K_MDU, K_MF}) continue;
`endif
      return i;
    end
    return -1;
  endfunction

  // Append the full expected cycle sequence of one instruction to exp_q.
  task automatic build(input logic [31:0] ins, input logic br);
    exp_t e;
    desc_t d;
    int i;
    logic rtype;
    i = lookup(ins);
    e = '0; e.irw = 1'b1; e.pcw = 1'b1; e.c_npc = 1'b1;
    exp_q.push_back(e);
    e = '0; e.st = 3'd1;
    if (i < 0) begin exp_q.push_back(e); return; end
    d = tbl[i];
    rtype = (d.op == 6'h00);
    case (d.kind)
      K_J:    begin e.pcw = 1; e.c_npc = 1; e.npc = 2; end
      K_JAL:  begin e.pcw = 1; e.c_npc = 1; e.npc = 2; e.rw = 1; e.c_rd = 1; e.rd = 2; e.c_m2r = 1; e.m2r = 2; end
      K_JR:   begin e.pcw = 1; e.c_npc = 1; e.npc = 3; end
      K_JALR: begin e.pcw = 1; e.c_npc = 1; e.npc = 3; e.rw = 1; e.c_rd = 1; e.rd = 1; e.c_m2r = 1; e.m2r = 2; end
      default: ;
    endcase
    exp_q.push_back(e);
    if (d.kind inside {K_J, K_JAL, K_JR, K_JALR}) return;
    e = '0; e.st = 3'd2;
    if (d.kind inside {K_BR, K_BRAL, K_LD, K_ST, K_ALU}) begin e.c_alu = 1; e.alu = d.alu; end
    if (d.kind inside {K_LD, K_ST, K_ALU}) begin e.c_src = 1; e.src = d.src; end
    if (d.kind inside {K_BR, K_BRAL} || (d.kind inside {K_LD, K_ST, K_ALU} && !rtype)) begin
      e.c_ext = 1; e.ext = d.ext;
    end
    case (d.kind)
      K_BR:   begin e.pcw = br; e.c_npc = 1; e.npc = 1; end
      K_BRAL: begin e.pcw = br; e.c_npc = 1; e.npc = 1; e.rw = 1; e.c_rd = 1; e.rd = 2; e.c_m2r = 1; e.m2r = 2; end
      K_MDU:  begin e.ms = 1; e.c_mop = 1; e.mop = 2'(ins[5:0] - 6'h18); end
      default: ;
    endcase
    exp_q.push_back(e);
    case (d.kind)
      K_LD: begin
        e = '0; e.st = 3'd3; exp_q.push_back(e);
        e = '0; e.st = 3'd4; e.rw = 1; e.c_rd = 1; e.rd = 0; e.c_m2r = 1; e.m2r = 1; exp_q.push_back(e);
      end
      K_ST: begin e = '0; e.st = 3'd3; e.mw = 1; exp_q.push_back(e); end
      K_ALU: begin
        e = '0; e.st = 3'd4; e.rw = 1; e.c_rd = 1; e.rd = rtype ? 2'd1 : 2'd0; e.c_m2r = 1; e.m2r = 0;
        exp_q.push_back(e);
      end
      K_MF: begin
        e = '0; e.st = 3'd4; e.rw = 1; e.c_rd = 1; e.rd = 1; e.c_m2r = 1; e.m2r = 3;
        e.c_mop = 1; e.mop = (ins[5:0] == 6'h12) ? 2'd1 : 2'd0;
        exp_q.push_back(e);
      end
      K_MDU: begin
        e = '0; e.st = 3'd5; e.mb = 1;
        repeat ((ins[5:0] >= 6'h1A) ? DIV_CYCLES : MULT_CYCLES) exp_q.push_back(e);
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      cmp("state", state, e.st);
      cmp("pc_write", pc_write, e.pcw);
      cmp("ir_write", ir_write, e.irw);
      cmp("reg_write", reg_write, e.rw);
      cmp("mem_write", mem_write, e.mw);
      cmp("mdu_start", mdu_start, e.ms);
      cmp("mdu_busy", mdu_busy, e.mb);
      if (e.c_npc) cmp("npc_sel", npc_sel, e.npc);
      if (e.c_rd)  cmp("reg_dst", reg_dst, e.rd);
      if (e.c_m2r) cmp("mem_to_reg", mem_to_reg, e.m2r);
      if (e.c_src) cmp("alu_src", alu_src, e.src);
      if (e.c_ext) cmp("ext_op", ext_op, e.ext);
      if (e.c_alu) cmp("alu_ctrl", alu_ctrl, e.alu);
      if (e.c_mop) cmp("mdu_op", mdu_op, e.mop);
    end
  end

  // Called in FETCH just after a rising edge; returns just after the next FETCH edge.
  task automatic run(input logic [31:0] ins, input logic br);
    int n;
    n = 0;
    instr = ins; br_taken = br;
    build(ins, br);
    do begin @(posedge clk); n++; end while (exp_q.size() != 0 && n < 64);
    #1;
  endtask

  function automatic logic [31:0] mk(input desc_t d);
    logic [31:0] r;
    r = $urandom;
    if (d.op == 6'h00) return {6'h00, r[25:6], d.sub};
    if (d.op == 6'h01) return {6'h01, r[25:21], d.sub[4:0], r[15:0]};
    return {d.op, r[25:0]};
  endfunction

  // Pins the model to hand-derived cycle counts and key fields; leaves exp_q empty.
  task automatic pin(input string name, input logic [31:0] ins, input logic br, input int len);
    build(ins, br);
    cmp({name, "_len"}, exp_q.size(), len);
    exp_q.delete();
  endtask

  initial begin
    int p;
    logic [31:0] ins;
    init_table();
    repeat (3) @(posedge clk);
    #1;
    cmp("rst_state", state, 3'd0);
    cmp("rst_strobes", {pc_write, ir_write, reg_write, mem_write, mdu_start}, 5'b0);
    reset = 1'b0;
    #1;
    cmp("post_rst_ir_write", ir_write, 1'b1);

    pin("m_addu", 32'h00221821, 1'b0, 4);
    build(32'h00221821, 1'b0);
    cmp("m_addu_alu", exp_q[2].alu, 5'b00010);
    cmp("m_addu_wb", {exp_q[3].rd, exp_q[3].m2r}, {2'd1, 2'd0});
    exp_q.delete();
    pin("m_lw", 32'h8C220004, 1'b0, 5);
    pin("m_sw", 32'hAC220004, 1'b0, 4);
    pin("m_beq", 32'h10220003, 1'b1, 3);
    pin("m_jal", 32'h0C000010, 1'b0, 2);
`ifdef MDU_SEQ_EN
    pin("m_mult", 32'h00220018, 1'b0, 3 + MULT_CYCLES);
    pin("m_div", 32'h0022001A, 1'b0, 3 + DIV_CYCLES);
`else
    pin("m_mult_off", 32'h00220018, 1'b0, 2);
`endif

    run(32'h00221821, 1'b0);  // addu $3,$1,$2
    run(32'h8C220004, 1'b0);  // lw
    run(32'hAC220004, 1'b0);  // sw
    run(32'h10220003, 1'b1);  // beq taken
    run(32'h10220003, 1'b0);  // beq not taken
    run(32'h0C000010, 1'b0);  // jal
    run(32'h08000010, 1'b0);  // j
    run(32'h03E00008, 1'b0);  // jr $31
    run(32'h0060F809, 1'b0);  // jalr $3
    run(32'h0431FFFE, 1'b0);  // bgezal not taken still links
    run(32'h3C01ABCD, 1'b0);  // lui
    run(32'h00000000, 1'b1);
    run(32'h00220018, 1'b0);  // mult (unknown without MDU)
    run(32'h00001812, 1'b0);  // mflo

    // Reset in MEM of a store must suppress mem_write.
    instr = 32'hAC220004;
    repeat (3) @(posedge clk);
    #1;
    cmp("sw_mem_state", state, 3'd3);
    cmp("sw_mem_write", mem_write, 1'b1);
    reset = 1'b1;
    #1;
    cmp("rst_gate_strobes", {pc_write, ir_write, reg_write, mem_write, mdu_start}, 5'b0);
    @(posedge clk);
    #1;
    cmp("rst_mid_state", state, 3'd0);
    cmp("rst_fetch_ir_write", ir_write, 1'b0);
    reset = 1'b0;
    #1;
    cmp("rel_ir_write", ir_write, 1'b1);

`ifdef MDU_SEQ_EN
    instr = 32'h0022001A;
    repeat (5) @(posedge clk);
    #1;
    cmp("div_wait_state", state, 3'd5);
    cmp("div_wait_busy", mdu_busy, 1'b1);
    reset = 1'b1;
    #1;
    cmp("div_rst_strobes", {pc_write, ir_write, reg_write, mem_write, mdu_start}, 5'b0);
    @(posedge clk);
    #1;
    cmp("div_rst_state", state, 3'd0);
    reset = 1'b0;
    #1;
    cmp("div_rel_ir_write", ir_write, 1'b1);
    run(32'h00220019, 1'b0);  // multu after abort: fresh count
    run(32'h00001810, 1'b0);  // mfhi
`endif

    foreach (tbl[i]) run(mk(tbl[i]), 1'($urandom_range(0, 1)));

    for (int k = 0; k < 400; k++) begin
      p = $urandom_range(0, 99);
      if (p < 85)      ins = mk(tbl[$urandom_range(0, tbl.size() - 1)]);
      else if (p < 95) ins = $urandom;
      else             ins = 32'h0;
      run(ins, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle successor to the single-cycle MIPS control decoder. It decodes the same instruction subset and alu_ctrl code space, but sequences each instruction through a FETCH/DECODE/EXEC/MEM/WB state machine. It sits beside the multi-cycle datapath (PC, IR, register file, ALU, data memory) and drives every datapath strobe per state. Optionally it also sequences a multi-cycle multiply/divide unit with a busy-wait state.

## Interface
Parameters:
- ALUOP_W, 5, alu_ctrl width (≥5); codes zero-extended.
- MULT_CYCLES, 5, MDU_WAIT duration for mult/multu (≥1).
- DIV_CYCLES, 10, MDU_WAIT duration for div/divu (≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- instr  in  32  IR contents; valid from DECODE onward.
- br_taken  in  1  ALU compare result for the branch in EXEC.
- pc_write  out  1  PC load strobe.
- ir_write  out  1  IR load strobe.
- reg_write  out  1  register file write strobe.
- mem_write  out  1  data memory write strobe.
- npc_sel  out  2  0=PC+4, 1=branch target, 2=j target, 3=rs (jr/jalr).
- reg_dst  out  2  0=rt, 1=rd, 2=$31.
- mem_to_reg  out  2  0=ALU, 1=memory, 2=PC+4, 3=HI/LO.
- alu_src  out  2  0=rt, 1=ext imm, 2=shamt.
- ext_op  out  2  0=sign, 1=zero, 2=lui (imm<<16), 3=branch (sign, <<2).
- alu_ctrl  out  ALUOP_W  team ALU code.
- mdu_start  out  1  one-cycle MDU start pulse.
- mdu_op  out  2  0=mult, 1=multu, 2=div, 3=divu; in WB also selects 0=HI, 1=LO.
- mdu_busy  out  1  high throughout MDU_WAIT.
- state  out  3  current state, for debug.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MDU_WAIT=5. Encodings 6 and 7 go to FETCH with no strobes.
- Outputs are combinational in (state, instr). Only the state register and the MDU counter are sequential.
- FETCH: ir_write=1, pc_write=1, npc_sel=0; next state DECODE.
- DECODE (next state FETCH unless noted):
  - instr==0 or an unknown opcode/funct: no strobes.
  - j: pc_write, npc_sel=2.
  - jal: additionally reg_write, reg_dst=2, mem_to_reg=2.
  - jr: pc_write, npc_sel=3.
  - jalr: additionally reg_write, reg_dst=1, mem_to_reg=2.
  - All other decoded instructions: next state EXEC.
- EXEC:
  - alu_ctrl/alu_src/ext_op driven per instruction: add/addu/addi/addiu/loads/stores 00010, sub/subu 00011, and/andi 00100, or/ori/lui 00101, xor/xori 00110, nor 00111, srl/srlv 01000, sra/srav 01001, sll/sllv 01010, slt/slti 01100, sltu/sltiu 01101.
  - Branch compare codes: beq 00110, bne 01011, blez 01110, bgtz 01111, bltz 00000, bgez 00001; ext_op=3.
  - Branches: pc_write=br_taken, npc_sel=1; next state FETCH. bgezal additionally reg_write, reg_dst=2, mem_to_reg=2, unconditionally.
  - Loads/stores: next state MEM. ALU R/I types and mfhi/mflo: next state WB.
  - mult/multu/div/divu: mdu_start=1; next state MDU_WAIT.
- MEM: store asserts mem_write=1, next state FETCH. Load has no strobe, next state WB.
- WB: reg_write=1; next state FETCH.
  - reg_dst=1 for R-type, else 0.
  - mem_to_reg=1 for loads, 3 for mfhi/mflo, else 0.
- MDU_WAIT:
  - Counter is loaded with MULT_CYCLES-1 or DIV_CYCLES-1 on EXEC→MDU_WAIT and decrements each cycle.
  - Exit to FETCH when the counter is 0.
  - Counter width is $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).

## Timing
- Reset: next edge gives state=FETCH and counter=0. While reset is high, every strobe (pc_write, ir_write, reg_write, mem_write, mdu_start) is forced 0.
- Reset wins from any state, including mid-MDU_WAIT. No strobe fires in the reset cycle.
- Cycles per instruction: jump 2, branch 3, store 4, ALU/mfhi/mflo 4, load 5, mult 3+MULT_CYCLES, div 3+DIV_CYCLES.
- mdu_start is high exactly one cycle per MDU instruction. mdu_busy is high for exactly MULT_CYCLES or DIV_CYCLES cycles.
- ir_write asserts only in FETCH. IR is therefore stable for the rest of the instruction.

## Configuration
- MDU_SEQ_EN defined: mult/multu/div/divu (funct 0x18–0x1B) and mfhi/mflo (0x10/0x12) are decoded as above.
- Undefined: those functs are unknown, so DECODE goes to FETCH with no strobes. mdu_start, mdu_busy and mdu_op are tied to 0. MDU_WAIT and the counter are removed.

## Test plan
- Assert reset during a DIV_CYCLES wait, then release: state=0, no strobe asserted, next FETCH has ir_write=1.
- addu $3,$1,$2: states 0,1,2,4. In WB: reg_write=1, reg_dst=1, mem_to_reg=0. In EXEC: alu_ctrl=00010.
- lw then sw: lw takes 5 cycles with WB mem_to_reg=1; sw takes 4 cycles with mem_write=1 only in MEM.
- beq with br_taken=1, then br_taken=0: pc_write=1/npc_sel=1 and pc_write=0 respectively, each in the 3rd cycle; jal gives reg_dst=2, mem_to_reg=2 in DECODE.
- MDU_SEQ_EN, MULT_CYCLES=5: mult gives a one-cycle mdu_start, mdu_busy high for 5 cycles, FETCH on cycle 9; then mflo gives WB mem_to_reg=3, mdu_op=1.
- Without MDU_SEQ_EN: funct 0x18 gives 2 cycles, no strobes, mdu_start never asserted.
